regfile: RTL
============

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter WIDTH, default 64, data width of each register in bits.
REQ-002 Parameter NREGS, default 32, number of registers; fixed at 32 because addresses are 5 bits.
REQ-003 Parameter ZERO_REG, default 31, index of the hardwired-zero register.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 RegWrite  input  1  write enable.
REQ-007 WriteRegister  input  5  write address.
REQ-008 WriteData  input  WIDTH  write data.
REQ-009 ReadRegister1  input  5  read port 1 address.
REQ-010 ReadRegister2  input  5  read port 2 address.
REQ-011 ReadData1  output  WIDTH  read port 1 data; combinational from address and state.
REQ-012 ReadData2  output  WIDTH  read port 2 data; combinational from address and state.

Function
REQ-013 Storage SHALL be NREGS registers of WIDTH bits each, built from per-bit D flip-flops with enable.
REQ-014 On a rising clk edge with RegWrite=1 and WriteRegister!=ZERO_REG, register[WriteRegister] SHALL take WriteData; every other register SHALL hold its value.
REQ-015 A write with RegWrite=0 SHALL leave every register unchanged.
REQ-016 A write addressed to ZERO_REG SHALL be discarded, and register ZERO_REG SHALL always read 0.
REQ-017 ReadDataN SHALL equal register[ReadRegisterN] with zero clock cycles of latency; the new value SHALL be visible after the edge that writes it.
REQ-018 Both read ports SHALL be independent; equal read addresses SHALL return identical data.
REQ-019 The write-port decoder SHALL assert exactly one register enable when RegWrite=1 and none when RegWrite=0.
REQ-020 Write and read of the same address in the same cycle without REGFILE_BYPASS_EN SHALL return the old value until the edge.

Reset
REQ-021 When reset=0, every register SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-022 While reset=0, writes SHALL be ignored, and ReadData1 and ReadData2 SHALL read 0.
REQ-023 On reset deassertion, the first write SHALL take effect on the first rising edge with reset=1.
REQ-024 Reset asserted in the middle of a cycle with a pending write SHALL cancel the write.

Configuration
REQ-025 When the macro REGFILE_BYPASS_EN is defined, a read port whose address equals WriteRegister, while RegWrite=1 and the address is not ZERO_REG, SHALL output WriteData combinationally in the same cycle.
REQ-026 When REGFILE_BYPASS_EN is undefined, no forwarding logic SHALL exist; behaviour SHALL be as in REQ-020.
REQ-027 Bypass SHALL never forward to ZERO_REG, and SHALL output 0 while reset=0.

Structure
REQ-028 Package regfile_pkg SHALL hold the constants REG_ADDR_W=5, NREGS=32, ZERO_REG=31 and the typedefs reg_addr_t and reg_data_t.
REQ-029 Sub-module decoder5_32 SHALL be used for write-enable decoding (inputs: 5-bit address and enable; output: 32-bit one-hot).
REQ-030 Read selection SHALL reuse the existing mux hierarchy: a 32:1 select per bit built from 8:1 and 4:1 muxes.

Verification
REQ-031 Reset: assert reset=0 with registers preloaded -> all reads 0 before the next clk edge; hold for 2 cycles -> still 0.
REQ-032 Basic write/read: write 64'hDEADBEEF_01234567 to X5 -> after the edge, ReadRegister1=5 returns that value and ReadRegister2=6 returns 0.
REQ-033 Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to X31 -> both ports read X31 as 0.
REQ-034 Write disable: RegWrite=0, WriteRegister=3, WriteData=64'h1234 -> X3 unchanged (0).
REQ-035 Sweep: write value i*64'h0101010101010101 to X0..X30 -> dual-port readback of all pairs matches; X31 reads 0.
REQ-036 Same-cycle read/write of X7 (old 64'hA, new 64'hB) -> before the edge, reads 64'hA without REGFILE_BYPASS_EN and 64'hB with it; after the edge, reads 64'hB in both builds.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file slice.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned ZERO_REG   = 31;
    localparam int unsigned DATA_W     = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

endpackage

// File: rtl/decoder5_32.sv
// Write-port decoder: one-hot register enable, all-zero when disabled.
module decoder5_32
    import regfile_pkg::*;
(
    input  reg_addr_t         addr,
    input  logic              en,
    output logic [NREGS-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mux.sv
// Read-select mux hierarchy: 32:1 built from four 8:1 muxes feeding a 4:1 mux.
module mux4_1 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [3:0][WIDTH-1:0] d,
    input  logic [1:0]            sel,
    output logic [WIDTH-1:0]      y
);

    always_comb begin
        y = d[sel];
    end

endmodule

module mux8_1 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [7:0][WIDTH-1:0] d,
    input  logic [2:0]            sel,
    output logic [WIDTH-1:0]      y
);

    always_comb begin
        y = d[sel];
    end

endmodule

module mux32_1
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [31:0][WIDTH-1:0] d,
    input  reg_addr_t              sel,
    output logic [WIDTH-1:0]       y
);

    logic [3:0][WIDTH-1:0] mid;

    for (genvar g = 0; g < 4; g++) begin : g_bank
        mux8_1 #(.WIDTH(WIDTH)) u_mux8 (
            .d   (d[g*8 +: 8]),
            .sel (sel[2:0]),
            .y   (mid[g])
        );
    end

    mux4_1 #(.WIDTH(WIDTH)) u_mux4 (
        .d   (mid),
        .sel (sel[4:3]),
        .y   (y)
    );

endmodule

// File: rtl/regfile.sv
// Two-read/one-write register file with a hardwired-zero register.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned NREGS    = regfile_pkg::NREGS,
    parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  reg_addr_t        WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  reg_addr_t        ReadRegister1,
    input  reg_addr_t        ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    logic [NREGS-1:0]            we;
    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]            rd1_q;
    logic [WIDTH-1:0]            rd2_q;

    decoder5_32 u_dec (
        .addr   (WriteRegister),
        .en     (RegWrite),
        .onehot (we)
    );

    // The zero register keeps its enable but always loads 0, so it can never hold data.
    for (genvar r = 0; r < int'(NREGS); r++) begin : g_reg
        localparam bit IS_ZERO = (r == int'(ZERO_REG));
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] q;

        always_comb begin
            d = IS_ZERO ? '0 : WriteData;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q <= '0;
            end else if (we[r]) begin
                q <= d;
            end
        end

        assign regs[r] = q;
    end

    mux32_1 #(.WIDTH(WIDTH)) u_rd1 (
        .d   (regs),
        .sel (ReadRegister1),
        .y   (rd1_q)
    );

    mux32_1 #(.WIDTH(WIDTH)) u_rd2 (
        .d   (regs),
        .sel (ReadRegister2),
        .y   (rd2_q)
    );

`ifdef REGFILE_BYPASS_EN
    localparam reg_addr_t ZADDR = reg_addr_t'(ZERO_REG);
    logic fwd_ok;

    always_comb begin
        fwd_ok    = RegWrite && (WriteRegister != ZADDR);
        ReadData1 = rd1_q;
        ReadData2 = rd2_q;
        if (fwd_ok && (ReadRegister1 == WriteRegister)) begin
            ReadData1 = WriteData;
        end
        if (fwd_ok && (ReadRegister2 == WriteRegister)) begin
            ReadData2 = WriteData;
        end
        if (!reset) begin
            ReadData1 = '0;
            ReadData2 = '0;
        end
    end
`else
    always_comb begin
        ReadData1 = reset ? rd1_q : '0;
        ReadData2 = reset ? rd2_q : '0;
    end
`endif

endmodule
